// File: rtl/lt24_bus_decoder.sv
// LT24 write-bus monitor: samples the ILI9341 write strobes and turns column/page
// window commands plus memory writes into per-pixel (x, y, colour) events.
module lt24_bus_decoder #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        LT24Wr_n,
  input  logic        LT24CS_n,
  input  logic        LT24RS,
  input  logic        LT24Reset_n,
  input  logic [15:0] LT24Data,
  output logic        pixelValid,
  output logic [7:0]  pixelX,
  output logic [8:0]  pixelY,
  output logic [15:0] pixelData,
  output logic        cmdValid,
  output logic [7:0]  cmdCode,
  output logic        frameDone,
  output logic        windowError
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COL_ARG  = 3'd1;
  localparam logic [2:0] PAGE_ARG = 3'd2;
  localparam logic [2:0] MEM_WR   = 3'd3;
  localparam logic [2:0] SKIP     = 3'd4;

  localparam logic [7:0] EC_DEF = 8'(WIDTH - 1);
  localparam logic [8:0] EP_DEF = 9'(HEIGHT - 1);
  localparam logic [8:0] W_LIM  = 9'(WIDTH);
  localparam logic [9:0] H_LIM  = 10'(HEIGHT);

  logic        wr_n_p1, cs_n_p1, rs_p1, rst_n_p1;
  logic [15:0] data_p1;
  logic        wr_n_p2;
  logic        vld_p1, cmd_evt, dat_evt;
  logic [2:0]  state;
  logic [1:0]  arg_cnt;
  logic [7:0]  sc, ec, cur_x;
  logic [8:0]  sp, ep, cur_y;
  logic [7:0]  arg_byte;
  logic [8:0]  ep_new;
  logic        col_bad, page_bad;

  // Stage 1: register every bus line; Stage 2: second copy of Wr_n for edge detect.
  // Strobe copies reset high so a strobe cut by reset never looks like a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_n_p1  <= 1'b1;
      cs_n_p1  <= 1'b1;
      rs_p1    <= 1'b0;
      rst_n_p1 <= 1'b1;
      wr_n_p2  <= 1'b1;
    end else begin
      wr_n_p1  <= LT24Wr_n;
      cs_n_p1  <= LT24CS_n;
      rs_p1    <= LT24RS;
      rst_n_p1 <= LT24Reset_n;
      wr_n_p2  <= wr_n_p1;
    end
  end

  always_ff @(posedge clock) begin
    data_p1 <= LT24Data;
  end

  assign vld_p1   = wr_n_p1 & ~wr_n_p2 & ~cs_n_p1 & rst_n_p1;
  assign cmd_evt  = vld_p1 & ~rs_p1;
  assign dat_evt  = vld_p1 & rs_p1;
  assign arg_byte = data_p1[7:0];
  assign ep_new   = {ep[8], arg_byte};
  // Checked on the final byte, so the start half is already in sc/sp.
  assign col_bad  = (sc > arg_byte) || ({1'b0, arg_byte} >= W_LIM);
  assign page_bad = (sp > ep_new) || ({1'b0, ep_new} >= H_LIM);

  // Decode stage: command/argument FSM, window registers and pixel pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      arg_cnt     <= 2'd0;
      sc          <= 8'd0;
      ec          <= EC_DEF;
      sp          <= 9'd0;
      ep          <= EP_DEF;
      cur_x       <= 8'd0;
      cur_y       <= 9'd0;
      pixelValid  <= 1'b0;
      pixelX      <= 8'd0;
      pixelY      <= 9'd0;
      pixelData   <= 16'd0;
      cmdValid    <= 1'b0;
      cmdCode     <= 8'd0;
      frameDone   <= 1'b0;
      windowError <= 1'b0;
    end else begin
      pixelValid <= 1'b0;
      cmdValid   <= 1'b0;
      frameDone  <= 1'b0;
      if (!rst_n_p1) begin
        // LCD reset clears the decode context but leaves cmdCode/windowError alone.
        state   <= IDLE;
        arg_cnt <= 2'd0;
        sc      <= 8'd0;
        ec      <= EC_DEF;
        sp      <= 9'd0;
        ep      <= EP_DEF;
        cur_x   <= 8'd0;
        cur_y   <= 9'd0;
      end else if (cmd_evt) begin
        cmdValid <= 1'b1;
        cmdCode  <= arg_byte;
        arg_cnt  <= 2'd0;
        case (arg_byte)
          8'h2A: state <= COL_ARG;
          8'h2B: state <= PAGE_ARG;
          8'h2C: begin
            state <= MEM_WR;
            cur_x <= sc;
            cur_y <= sp;
          end
          8'h3C:   state <= MEM_WR;
          default: state <= SKIP;
        endcase
      end else if (dat_evt) begin
        case (state)
          COL_ARG: begin
            case (arg_cnt)
              2'd1:    sc <= arg_byte;
              2'd3:    ec <= arg_byte;
              default: ;
            endcase
            arg_cnt <= arg_cnt + 2'd1;
            if (arg_cnt == 2'd3) begin
              state <= IDLE;
              if (col_bad) windowError <= 1'b1;
            end
          end
          PAGE_ARG: begin
            case (arg_cnt)
              2'd0: sp[8]   <= data_p1[0];
              2'd1: sp[7:0] <= arg_byte;
              2'd2: ep[8]   <= data_p1[0];
              2'd3: ep[7:0] <= arg_byte;
            endcase
            arg_cnt <= arg_cnt + 2'd1;
            if (arg_cnt == 2'd3) begin
              state <= IDLE;
              if (page_bad) windowError <= 1'b1;
            end
          end
          MEM_WR: begin
            pixelValid <= 1'b1;
            pixelX     <= cur_x;
            pixelY     <= cur_y;
            pixelData  <= data_p1;
            // Equality-only stepping keeps an inverted window deterministic.
            if (cur_x != ec) begin
              cur_x <= cur_x + 8'd1;
            end else if (cur_y != ep) begin
              cur_x <= sc;
              cur_y <= cur_y + 9'd1;
            end else begin
              frameDone <= 1'b1;
              cur_x     <= sc;
              cur_y     <= sp;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
